// File: rtl/adder_pkg.sv
// Shared types for the FP adder arbiter: float width, arbiter states and the
// stb-qualified data channel used on the adder side.
package adder_pkg;

    localparam int unsigned FLOAT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_SEND_A,
        ST_SEND_B,
        ST_WAIT_Z,
        ST_RESP
    } arb_state_t;

    typedef struct packed {
        logic [FLOAT_W-1:0] data;
        logic               stb;
    } hs_chan_t;

endpackage

// File: rtl/adder_rr_select.sv
// Winner selection among requesters. Round-robin from i_ptr by default;
// fixed lowest-index priority when ADDER_ARB_PRIORITY_EN is defined.
module adder_rr_select #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

`ifdef ADDER_ARB_PRIORITY_EN
    logic w_ptr_unused;
    assign w_ptr_unused = ^i_ptr;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!o_valid && i_req[IDX_W'(k)]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(k);
            end
        end
    end
`else
    // First set request in the order ptr, ptr+1, ... wrapping modulo N.
    always_comb begin
        int unsigned pos;
        pos     = 0;
        o_valid = 1'b0;
        o_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = (32'(i_ptr) + k) % N;
            if (!o_valid && i_req[IDX_W'(pos)]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(pos);
            end
        end
    end
`endif

endmodule

// File: rtl/adder_arbiter.sv
// Shares one FP adder among N requesters; one operation in flight at a time.
// Arbitration policy is set in adder_rr_select (ADDER_ARB_PRIORITY_EN).
module adder_arbiter
    import adder_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*FLOAT_W-1:0] req_a,
    input  logic [N*FLOAT_W-1:0] req_b,
    input  logic [N-1:0]         req_stb,
    output logic [N-1:0]         req_ack,
    output logic [FLOAT_W-1:0]   resp_z,
    output logic [N-1:0]         resp_stb,
    input  logic [N-1:0]         resp_ack,
    output logic [FLOAT_W-1:0]   adder_a,
    output logic                 adder_a_stb,
    input  logic                 adder_a_ack,
    output logic [FLOAT_W-1:0]   adder_b,
    output logic                 adder_b_stb,
    input  logic                 adder_b_ack,
    input  logic [FLOAT_W-1:0]   adder_z,
    input  logic                 adder_z_stb,
    output logic                 adder_z_ack
);

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_ptr;
    logic [FLOAT_W-1:0] r_op_b;
    logic [N-1:0]       r_req_ack;
    logic [N-1:0]       r_resp_stb;
    logic [FLOAT_W-1:0] r_resp_z;
    hs_chan_t           r_adder_a;
    hs_chan_t           r_adder_b;
    logic               r_adder_z_ack;

    logic [FLOAT_W-1:0] w_req_a [N];
    logic [FLOAT_W-1:0] w_req_b [N];
    logic               w_sel_valid;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_req_xfer;
    logic               w_a_xfer;
    logic               w_b_xfer;
    logic               w_z_xfer;
    logic               w_resp_xfer;

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign w_req_a[gi] = req_a[gi*FLOAT_W +: FLOAT_W];
        assign w_req_b[gi] = req_b[gi*FLOAT_W +: FLOAT_W];
    end

    adder_rr_select #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_select (
        .i_req   (req_stb),
        .i_ptr   (r_ptr),
        .o_valid (w_sel_valid),
        .o_idx   (w_sel_idx)
    );

    assign w_req_xfer  = req_stb[r_grant] & r_req_ack[r_grant];
    assign w_a_xfer    = r_adder_a.stb & adder_a_ack;
    assign w_b_xfer    = r_adder_b.stb & adder_b_ack;
    assign w_z_xfer    = adder_z_stb & r_adder_z_ack;
    assign w_resp_xfer = r_resp_stb[r_grant] & resp_ack[r_grant];

    // Arbiter FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_ptr         <= '0;
            r_op_b        <= '0;
            r_req_ack     <= '0;
            r_resp_stb    <= '0;
            r_resp_z      <= '0;
            r_adder_a     <= '0;
            r_adder_b     <= '0;
            r_adder_z_ack <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        r_grant   <= w_sel_idx;
                        r_req_ack <= N'(1) << w_sel_idx;
                        r_state   <= ST_GRANT;
                    end
                end
                // A requester dropping stb here is a violation; ack is held until it returns.
                ST_GRANT: begin
                    if (w_req_xfer) begin
                        r_req_ack      <= '0;
                        r_op_b         <= w_req_b[r_grant];
                        r_adder_a.data <= w_req_a[r_grant];
                        r_adder_a.stb  <= 1'b1;
                        r_state        <= ST_SEND_A;
                    end
                end
                ST_SEND_A: begin
                    if (w_a_xfer) begin
                        r_adder_a.stb  <= 1'b0;
                        r_adder_b.data <= r_op_b;
                        r_adder_b.stb  <= 1'b1;
                        r_state        <= ST_SEND_B;
                    end
                end
                ST_SEND_B: begin
                    if (w_b_xfer) begin
                        r_adder_b.stb <= 1'b0;
                        r_adder_z_ack <= 1'b1;
                        r_state       <= ST_WAIT_Z;
                    end
                end
                ST_WAIT_Z: begin
                    if (w_z_xfer) begin
                        r_adder_z_ack <= 1'b0;
                        r_resp_z      <= adder_z;
                        r_resp_stb    <= N'(1) << r_grant;
                        r_state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_resp_xfer) begin
                        r_resp_stb <= '0;
`ifndef ADDER_ARB_PRIORITY_EN
                        r_ptr <= (32'(r_grant) == N - 1) ? '0 : r_grant + IDX_W'(1);
`endif
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ack     = r_req_ack;
    assign resp_stb    = r_resp_stb;
    assign resp_z      = r_resp_z;
    assign adder_a     = r_adder_a.data;
    assign adder_a_stb = r_adder_a.stb;
    assign adder_b     = r_adder_b.data;
    assign adder_b_stb = r_adder_b.stb;
    assign adder_z_ack = r_adder_z_ack;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: behavioural FP adder, requester drivers and a
// scoreboard of expected sums pushed when each operand pair is presented.
module tb_adder_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned W = 32;

    logic             clk;
    logic             rst;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_stb;
    logic [N-1:0]     req_ack;
    logic [W-1:0]     resp_z;
    logic [N-1:0]     resp_stb;
    logic [N-1:0]     resp_ack;
    logic [W-1:0]     adder_a;
    logic             adder_a_stb;
    logic             adder_a_ack;
    logic [W-1:0]     adder_b;
    logic             adder_b_stb;
    logic             adder_b_ack;
    logic [W-1:0]     adder_z;
    logic             adder_z_stb;
    logic             adder_z_ack;

    adder_arbiter #(.N(N), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
        .resp_z(resp_z), .resp_stb(resp_stb), .resp_ack(resp_ack),
        .adder_a(adder_a), .adder_a_stb(adder_a_stb), .adder_a_ack(adder_a_ack),
        .adder_b(adder_b), .adder_b_stb(adder_b_stb), .adder_b_ack(adder_b_ack),
        .adder_z(adder_z), .adder_z_stb(adder_z_stb), .adder_z_ack(adder_z_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [7:0]   idx;
        logic [W-1:0] z;
    } exp_t;

    exp_t        sb[$];
    int          glog[$];
    int          total;
    int          bad;
    int          cyc;
    int          resp_count;
    int          remaining[N];
    int          resp_wcnt[N];
    int          raise_cyc[N];
    int          ack_lat[N];
    int          waitg[N];
    int          resp_len_by[N];
    int          resp_len_cur;
    logic [W-1:0] last_resp_z[N];
    logic [W-1:0] dir_a[N];
    logic [W-1:0] dir_b[N];
    bit          rand_ops;
    bit          rand_stall;
    int          resp_delay;
    bit          z_hold;
    bit          m_have_a;
    bit          m_have_b;
    int          m_zdelay;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic [W-1:0] cur_a;
    logic [W-1:0] cur_b;

    // Truncating add for positive normal operands; enough for the stimulus used here.
    function automatic logic [W-1:0] fp_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic [7:0]   e;
        logic [24:0]  mh;
        logic [24:0]  ml;
        int unsigned  d;
        if (x[30:23] >= y[30:23]) begin hi = x; lo = y; end
        else begin hi = y; lo = x; end
        d  = 32'(hi[30:23]) - 32'(lo[30:23]);
        mh = {2'b01, hi[22:0]};
        ml = (d > 24) ? 25'd0 : ({2'b01, lo[22:0]} >> d);
        mh = mh + ml;
        e  = hi[30:23];
        if (mh[24]) begin
            mh = mh >> 1;
            e  = e + 8'd1;
        end
        return {1'b0, e, mh[22:0]};
    endfunction

    function automatic logic [W-1:0] rnd_float();
        logic [7:0]  e;
        logic [22:0] m;
        e = 8'($urandom_range(100, 150));
        m = 23'($urandom);
        return {1'b0, e, m};
    endfunction

    // One clock: sample pre-edge handshakes, advance, then run checks and drivers.
    task automatic step();
        logic [N-1:0] p_req_x, p_resp_x, p_resp_stb, p_req_ack;
        logic         p_a_x, p_b_x, p_z_x, p_rst, p_a_stb, p_b_stb;
        logic [W-1:0] p_resp_z, p_adder_a, p_adder_b;
        int           found;
        logic [W-1:0] a, b;
        p_req_x    = req_stb & req_ack;
        p_resp_x   = resp_stb & resp_ack;
        p_resp_stb = resp_stb;
        p_req_ack  = req_ack;
        p_a_x      = adder_a_stb & adder_a_ack;
        p_b_x      = adder_b_stb & adder_b_ack;
        p_z_x      = adder_z_stb & adder_z_ack;
        p_a_stb    = adder_a_stb;
        p_b_stb    = adder_b_stb;
        p_resp_z   = resp_z;
        p_adder_a  = adder_a;
        p_adder_b  = adder_b;
        p_rst      = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (p_rst) begin
            sb.delete();
            req_stb = '0; resp_ack = '0;
            adder_a_ack = 1'b0; adder_b_ack = 1'b0; adder_z_stb = 1'b0;
            m_have_a = 1'b0; m_have_b = 1'b0; resp_len_cur = 0;
            for (int i = 0; i < N; i++) begin
                remaining[i] = 0; resp_wcnt[i] = 0; waitg[i] = 0;
            end
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (p_req_x[i]) begin
                glog.push_back(i);
                cur_a = req_a[i*W +: W];
                cur_b = req_b[i*W +: W];
`ifndef ADDER_ARB_PRIORITY_EN
                total++;
                if (waitg[i] > N - 1) begin
                    bad++;
                    $display("FAIL starvation: requester %0d waited %0d grants, limit %0d", i, waitg[i], N - 1);
                end
`endif
                for (int j = 0; j < N; j++)
                    if (j != i && req_stb[j]) waitg[j]++;
                waitg[i] = 0;
                req_stb[i] = 1'b0;
            end
            if (req_ack[i] && !p_req_ack[i]) ack_lat[i] = cyc - raise_cyc[i];
        end
        total++;
        if (!$onehot0(req_ack) || !$onehot0(resp_stb) || (resp_stb != '0 && req_ack != '0)) begin
            bad++;
            $display("FAIL onehot: req_ack=%b resp_stb=%b, need one-hot0 and not both", req_ack, resp_stb);
        end
        if (p_resp_stb != '0 && p_resp_x == '0) begin
            total++;
            if (resp_stb !== p_resp_stb || resp_z !== p_resp_z) begin
                bad++;
                $display("FAIL resp_hold: stb=%b z=%h, need stb=%b z=%h", resp_stb, resp_z, p_resp_stb, p_resp_z);
            end
        end
        if ((p_a_stb && !p_a_x) || (p_b_stb && !p_b_x)) begin
            total++;
            if ((p_a_stb && !p_a_x && (adder_a_stb !== 1'b1 || adder_a !== p_adder_a)) ||
                (p_b_stb && !p_b_x && (adder_b_stb !== 1'b1 || adder_b !== p_adder_b))) begin
                bad++;
                $display("FAIL adder_hold: a=%h/%b b=%h/%b, need a=%h b=%h held", adder_a, adder_a_stb,
                         adder_b, adder_b_stb, p_adder_a, p_adder_b);
            end
        end
        if (p_a_x) begin
            total++;
            if (p_adder_a !== cur_a) begin
                bad++;
                $display("FAIL adder_a: got %h, need %h", p_adder_a, cur_a);
            end
            m_a = p_adder_a; m_have_a = 1'b1;
        end
        if (p_b_x) begin
            total++;
            if (p_adder_b !== cur_b) begin
                bad++;
                $display("FAIL adder_b: got %h, need %h", p_adder_b, cur_b);
            end
            m_b = p_adder_b; m_have_b = 1'b1;
            m_zdelay = rand_stall ? int'($urandom_range(0, 4)) : 0;
        end
        if (p_z_x) begin
            adder_z_stb = 1'b0; m_have_a = 1'b0; m_have_b = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (p_resp_x[i]) begin
                found = -1;
                for (int k = 0; k < sb.size(); k++)
                    if (found < 0 && int'(sb[k].idx) == i) found = k;
                total++;
                if (found < 0) begin
                    bad++;
                    $display("FAIL resp_unexpected: requester %0d got %h, none outstanding", i, p_resp_z);
                end else begin
                    if (p_resp_z !== sb[found].z) begin
                        bad++;
                        $display("FAIL resp_z: requester %0d got %h, need %h", i, p_resp_z, sb[found].z);
                    end
                    sb.delete(found);
                end
                last_resp_z[i] = p_resp_z;
                resp_len_by[i] = resp_len_cur;
                resp_len_cur = 0;
                resp_ack[i] = 1'b0;
                resp_wcnt[i] = 0;
                resp_count++;
            end
        end
        if (resp_stb != '0) resp_len_cur++;
        // Adder side.
        adder_a_ack = !m_have_a && (!rand_stall || $urandom_range(0, 1) == 0);
        adder_b_ack = m_have_a && !m_have_b && (!rand_stall || $urandom_range(0, 1) == 0);
        if (m_have_b && !adder_z_stb && !z_hold) begin
            if (m_zdelay > 0) m_zdelay--;
            else begin
                adder_z = fp_add(m_a, m_b);
                adder_z_stb = 1'b1;
            end
        end
        // Requester side.
        for (int i = 0; i < N; i++) begin
            if (resp_stb[i] && !resp_ack[i]) begin
                resp_wcnt[i]++;
                if (rand_stall ? ($urandom_range(0, 2) == 0) : (resp_wcnt[i] >= resp_delay))
                    resp_ack[i] = 1'b1;
            end
            if (!req_stb[i] && remaining[i] > 0 && (!rand_stall || $urandom_range(0, 3) == 0)) begin
                a = rand_ops ? rnd_float() : dir_a[i];
                b = rand_ops ? rnd_float() : dir_b[i];
                req_a[i*W +: W] = a;
                req_b[i*W +: W] = b;
                sb.push_back('{idx: 8'(i), z: fp_add(a, b)});
                req_stb[i] = 1'b1;
                raise_cyc[i] = cyc;
                remaining[i]--;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            step();
            n++;
            busy = (sb.size() != 0);
            for (int i = 0; i < N; i++) if (remaining[i] != 0) busy = 1'b1;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL timeout: still busy after %0d cycles, outstanding=%0d", budget, sb.size());
        end
    endtask

    task automatic wait_grants(input int n, input int budget);
        int c;
        c = 0;
        while (glog.size() < n && c < budget) begin
            step();
            c++;
        end
        total++;
        if (glog.size() < n) begin
            bad++;
            $display("FAIL grant_timeout: %0d grants seen, need %0d", glog.size(), n);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if (req_ack !== '0 || resp_stb !== '0) begin
            bad++;
            $display("FAIL reset_req_resp: req_ack=%b resp_stb=%b, need 0", req_ack, resp_stb);
        end
        total++;
        if (resp_z !== '0) begin
            bad++;
            $display("FAIL reset_resp_z: got %h, need 0", resp_z);
        end
        total++;
        if (adder_a_stb !== 1'b0 || adder_b_stb !== 1'b0 || adder_z_ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_adder_ctl: a_stb=%b b_stb=%b z_ack=%b, need 0", adder_a_stb, adder_b_stb, adder_z_ack);
        end
        total++;
        if (adder_a !== '0 || adder_b !== '0) begin
            bad++;
            $display("FAIL reset_adder_data: a=%h b=%h, need 0", adder_a, adder_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        glog.delete();
        dir_a[0] = 32'h3F800000;
        dir_b[0] = 32'h40000000;
        remaining[0] = 1;
        wait_idle(200);
        total++;
        if (ack_lat[0] !== 1) begin
            bad++;
            $display("FAIL single_ack_latency: got %0d, need 1", ack_lat[0]);
        end
        total++;
        if (last_resp_z[0] !== 32'h40400000) begin
            bad++;
            $display("FAIL single_resp_z: got %h, need 40400000", last_resp_z[0]);
        end
        total++;
        if (glog.size() != 1 || glog[0] != 0) begin
            bad++;
            $display("FAIL single_grant: %0d grants first=%0d, need one grant to 0", glog.size(), glog[0]);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        glog.delete();
        for (int i = 0; i < N; i++) begin
            dir_a[i] = 32'h3F800000;
            dir_b[i] = 32'h3F000000;
            remaining[i] = 1;
        end
        wait_idle(400);
        for (int i = 0; i < N; i++) begin
            total++;
            if (glog.size() <= i || glog[i] != i) begin
                bad++;
                $display("FAIL simul_order: slot %0d granted %0d, need %0d", i, (glog.size() > i) ? glog[i] : -1, i);
            end
            total++;
            if (last_resp_z[i] !== 32'h3FC00000) begin
                bad++;
                $display("FAIL simul_resp_z: requester %0d got %h, need 3FC00000", i, last_resp_z[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp_order[4];
`ifdef ADDER_ARB_PRIORITY_EN
        exp_order = '{1, 1, 1, 2};
`else
        exp_order = '{1, 2, 1, 1};
`endif
        glog.delete();
        dir_a[1] = 32'h3F800000; dir_b[1] = 32'h40000000;
        dir_a[2] = 32'h40000000; dir_b[2] = 32'h3F000000;
        remaining[1] = 3;
        wait_grants(1, 50);
        remaining[2] = 1;
        wait_idle(400);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (glog.size() <= i || glog[i] != exp_order[i]) begin
                bad++;
                $display("FAIL b2b_order: slot %0d granted %0d, need %0d", i, (glog.size() > i) ? glog[i] : -1, exp_order[i]);
            end
        end
    endtask

    task automatic test_resp_delay();
        glog.delete();
        resp_delay = 5;
        dir_a[2] = 32'h3F800000; dir_b[2] = 32'h3F800000;
        dir_a[3] = 32'h3F800000; dir_b[3] = 32'h40000000;
        remaining[2] = 1;
        wait_grants(1, 50);
        remaining[3] = 1;
        wait_idle(400);
        total++;
        if (resp_len_by[2] != 5) begin
            bad++;
            $display("FAIL resp_delay_len: resp_stb high %0d cycles, need 5", resp_len_by[2]);
        end
        total++;
        if (last_resp_z[2] !== 32'h40000000) begin
            bad++;
            $display("FAIL resp_delay_z: got %h, need 40000000", last_resp_z[2]);
        end
        total++;
        if (glog.size() != 2 || glog[1] != 3) begin
            bad++;
            $display("FAIL resp_delay_order: %0d grants, need 2 ending with 3", glog.size());
        end
        resp_delay = 1;
    endtask

    task automatic test_reset_mid();
        int c;
        glog.delete();
        z_hold = 1'b1;
        dir_a[0] = 32'h3F800000; dir_b[0] = 32'h3F800000;
        remaining[0] = 1;
        c = 0;
        while (adder_z_ack !== 1'b1 && c < 100) begin
            step();
            c++;
        end
        total++;
        if (adder_z_ack !== 1'b1) begin
            bad++;
            $display("FAIL mid_reach_wait_z: z_ack=%b, need 1", adder_z_ack);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        z_hold = 1'b0;
        total++;
        if ({req_ack, resp_stb, adder_a_stb, adder_b_stb, adder_z_ack} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: req_ack=%b resp_stb=%b a=%b b=%b z_ack=%b, need 0",
                     req_ack, resp_stb, adder_a_stb, adder_b_stb, adder_z_ack);
        end
        glog.delete();
        dir_a[2] = 32'h3F800000; dir_b[2] = 32'h40000000;
        remaining[2] = 1;
        wait_idle(200);
        total++;
        if (ack_lat[2] != 1) begin
            bad++;
            $display("FAIL mid_after_ack_latency: got %0d, need 1", ack_lat[2]);
        end
        total++;
        if (last_resp_z[2] !== 32'h40400000 || glog.size() != 1) begin
            bad++;
            $display("FAIL mid_after_resp: z=%h grants=%0d, need 40400000 and 1", last_resp_z[2], glog.size());
        end
    endtask

    task automatic test_random();
        int start;
        start = resp_count;
        rand_ops = 1'b1;
        rand_stall = 1'b1;
        for (int i = 0; i < N; i++) remaining[i] = 250;
        wait_idle(60000);
        total++;
        if (resp_count - start != 1000) begin
            bad++;
            $display("FAIL random_count: %0d responses, need 1000", resp_count - start);
        end
        rand_ops = 1'b0;
        rand_stall = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; resp_count = 0; resp_len_cur = 0;
        rst = 1'b1;
        req_a = '0; req_b = '0; req_stb = '0; resp_ack = '0;
        adder_a_ack = 1'b0; adder_b_ack = 1'b0; adder_z = '0; adder_z_stb = 1'b0;
        rand_ops = 1'b0; rand_stall = 1'b0; resp_delay = 1; z_hold = 1'b0;
        m_have_a = 1'b0; m_have_b = 1'b0; m_zdelay = 0; m_a = '0; m_b = '0;
        cur_a = '0; cur_b = '0;
        for (int i = 0; i < N; i++) begin
            remaining[i] = 0; resp_wcnt[i] = 0; raise_cyc[i] = 0; ack_lat[i] = -1;
            waitg[i] = 0; resp_len_by[i] = 0; last_resp_z[i] = '0;
            dir_a[i] = '0; dir_b[i] = '0;
        end
        test_reset();
        test_single();
        test_simultaneous();
        test_back_to_back();
        test_resp_delay();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
